// File: rtl/fusion_pkg.sv
// fusion_pkg
//   Shared definitions for the fused-instruction expander:
//   - micro-op opcode constants placed in bits [15:12] of expanded beats
//   - fusion-type encodings carried alongside each fused instruction
//   - the expander FSM state enum
package fusion_pkg;

    localparam logic [3:0] OP_LOAD   = 4'h7;
    localparam logic [3:0] OP_STORE  = 4'h6;
    localparam logic [3:0] OP_CUSTOM = 4'hF;

    typedef enum logic [1:0] {
        FUSE_NONE    = 2'd0,
        FUSE_LOAD    = 2'd1,
        FUSE_STORE   = 2'd2,
        FUSE_COMPUTE = 2'd3
    } fuse_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } exp_state_e;

endpackage

// File: rtl/onehot_lsb_pick.sv
// onehot_lsb_pick
//   Picks the lowest set bit of a 4-bit mask.
//   Ports:
//     mask   in  4 : mask to examine
//     onehot out 4 : one-hot of the lowest set bit (0 when mask is 0)
//     single out 1 : mask has exactly one bit set
module onehot_lsb_pick (
    input  logic [3:0] mask,
    output logic [3:0] onehot,
    output logic       single
);

    // Two's-complement trick: x & -x isolates the lowest set bit.
    assign onehot = mask & (~mask + 4'd1);

    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign single = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);

endmodule

// File: rtl/fused_op_expander.sv
// fused_op_expander
//   Expands one fused instruction into 1-4 ordered micro-ops.
//   Build option: FUSED_OP_STATS_EN enables the expand/uop counters;
//   without it both counter outputs read 0 and no counter flops exist.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   Valid-side signals (uop, uop_last) hold stable while valid is high and
//   ready is low. in_ready depends only on FSM state.
//
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     in_instr[15:0] : fused instruction
//     in_type[1:0]   : fusion type (none/load/store/compute)
//     in_valid/in_ready : input handshake
//     uop[15:0], uop_valid/uop_ready, uop_last : micro-op output handshake
//     expand_count[31:0] : accepted inputs with nonzero type
//     uop_count[31:0]    : completed micro-op handshakes
module fused_op_expander
    import fusion_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_instr,
    input  logic [1:0]  in_type,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] uop,
    output logic        uop_valid,
    input  logic        uop_ready,
    output logic        uop_last,
    output logic [31:0] expand_count,
    output logic [31:0] uop_count
);

    exp_state_e  state, state_nxt;

    logic [15:0] hold_instr;
    fuse_type_e  hold_type;
    logic [3:0]  hold_mask;   // remaining compute-fuse bits
    logic        hold_beat;   // beat index for load/store fuse

    logic [3:0]  pick_onehot;
    logic        pick_single;

    logic [15:0] beat_uop;
    logic        beat_last;
    logic        in_fire;
    logic        uop_fire;

    onehot_lsb_pick u_pick (
        .mask   (hold_mask),
        .onehot (pick_onehot),
        .single (pick_single)
    );

    // Current beat content, derived from the holding register.
    always_comb begin
        beat_uop  = hold_instr;
        beat_last = 1'b1;
        case (hold_type)
            FUSE_NONE: begin
                beat_uop  = hold_instr;
                beat_last = 1'b1;
            end
            FUSE_LOAD: begin
                beat_uop  = hold_beat ? {hold_instr[15:6], 6'b0}
                                      : {OP_LOAD, hold_instr[8:6], 3'b000, hold_instr[5:0]};
                beat_last = hold_beat;
            end
            FUSE_STORE: begin
                beat_uop  = hold_beat ? {OP_STORE, hold_instr[11:9], 3'b000, hold_instr[5:0]}
                                      : {hold_instr[15:6], 6'b0};
                beat_last = hold_beat;
            end
            FUSE_COMPUTE: begin
                // The mask only reaches zero here if it was zero at latch,
                // because the last set bit is never cleared.
                if (hold_mask == 4'd0) begin
                    beat_uop  = hold_instr;
                    beat_last = 1'b1;
                end else begin
                    beat_uop  = {hold_instr[15:10], pick_onehot, hold_instr[5:0]};
                    beat_last = pick_single;
                end
            end
            default: begin
                beat_uop  = hold_instr;
                beat_last = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        uop_valid = 1'b0;
        uop       = 16'd0;
        uop_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                uop_valid = 1'b1;
                uop       = beat_uop;
                uop_last  = beat_last;
                if (uop_ready && beat_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign uop_fire = uop_valid && uop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= 16'd0;
            hold_type  <= FUSE_NONE;
            hold_mask  <= 4'd0;
            hold_beat  <= 1'b0;
        end else if (in_fire) begin
            hold_instr <= in_instr;
            hold_type  <= fuse_type_e'(in_type);
            hold_mask  <= in_instr[9:6];
            hold_beat  <= 1'b0;
        end else if (uop_fire && !uop_last) begin
            hold_beat <= 1'b1;
            hold_mask <= hold_mask & ~pick_onehot;
        end
    end

`ifdef FUSED_OP_STATS_EN
    logic [31:0] expand_cnt_q;
    logic [31:0] uop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expand_cnt_q <= 32'd0;
            uop_cnt_q    <= 32'd0;
        end else begin
            if (in_fire && (in_type != 2'd0)) expand_cnt_q <= expand_cnt_q + 32'd1;
            if (uop_fire)                     uop_cnt_q    <= uop_cnt_q + 32'd1;
        end
    end

    assign expand_count = expand_cnt_q;
    assign uop_count    = uop_cnt_q;
`else
    assign expand_count = 32'd0;
    assign uop_count    = 32'd0;
`endif

endmodule
